router_fifo_pkt: RTL and testbench
==================================

ROUTER_FIFO_PKT -- requirements
Module: router_fifo_pkt

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data byte width (legal >= 3).
REQ-002 SHALL have parameter DEPTH, default 16, entries (power of two, >= 4).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold in entries.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port soft_reset  input  1  synchronous flush, active-high.
REQ-007 SHALL have port write_enb  input  1  write request.
REQ-008 SHALL have port read_enb  input  1  read request.
REQ-009 SHALL have port lfd_state  input  1  marks data_in as packet header.
REQ-010 SHALL have port data_in  input  DATA_W  write data.
REQ-011 SHALL have port data_out  output  DATA_W  registered read data.
REQ-012 SHALL have port data_valid  output  1  data_out carries a byte read last cycle.
REQ-013 SHALL have port sop_out / eop_out  output  1 each  data_out is header / final (parity) byte.
REQ-014 SHALL have ports empty, full, almost_full  output  1 each  occupancy flags.
REQ-015 SHALL have port fill_level  output  $clog2(DEPTH)+1  current entry count.
REQ-016 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 SHALL store DEPTH entries of DATA_W+1 bits: data plus lfd flag.
REQ-018 SHALL accept a write when write_enb=1 and (full=0 or read accepted same cycle).
REQ-019 SHALL accept a read when read_enb=1 and empty=0; read when empty is ignored.
REQ-020 Simultaneous accepted read and write SHALL leave fill_level unchanged, including at full; at empty only the write occurs.
REQ-021 Pointers SHALL wrap modulo DEPTH; fill_level SHALL be a separate counter, 0..DEPTH.
REQ-022 empty = (fill_level==0), full = (fill_level==DEPTH), almost_full = (fill_level>=AF_LEVEL), all derived from registered fill_level.
REQ-023 Read latency SHALL be one cycle: data_out, data_valid, sop_out, eop_out update on the edge that accepts the read; data_valid=0 and data_out holds on cycles with no accepted read.
REQ-024 Packet tracker: reading an entry with lfd flag SHALL load byte counter with header[DATA_W-1:2]+1 and assert sop_out.
REQ-025 Each subsequent accepted non-header read SHALL decrement the counter; eop_out SHALL assert with the byte that brings it from 1 to 0.
REQ-026 A header read while counter is nonzero SHALL reload the counter (truncated packet), no error flag.
REQ-027 overflow SHALL set when write_enb=1 is rejected due to full; underflow when read_enb=1 with empty=1; both sticky until reset or soft_reset.
REQ-028 soft_reset SHALL clear pointers, fill_level, byte counter, data_out, flags, and take priority over reads/writes that cycle.

Reset
REQ-029 resetn=0 SHALL asynchronously force: pointers 0, fill_level 0, empty 1, full 0, almost_full 0, data_out 0, data_valid 0, sop_out 0, eop_out 0, overflow 0, underflow 0, byte counter 0.
REQ-030 Memory array contents SHALL not require reset; no read may expose uninitialised entries.
REQ-031 Reset deassertion mid-packet SHALL leave the block idle-empty; no partial packet survives.

Structure
REQ-032 Shared package router_pkg SHALL hold default DATA_W, header length field position (bits DATA_W-1:2), address field (bits 1:0).
REQ-033 Storage SHALL be one sub-module router_fifo_mem (1 write port, 1 synchronous read port, no reset); control, flags and packet tracker in router_fifo_pkt.

Verification
REQ-034 Reset then write header 0x31 (len 12, addr 01) + 12 payload + parity, then read all -> 14 bytes in order, sop_out on byte 1, eop_out on byte 14, fill_level 14->0, empty=1 after.
REQ-035 Write 16 bytes without read -> full=1, almost_full=1 from 14th write; 17th write rejected, overflow=1, fill_level stays 16.
REQ-036 At full, assert read_enb and write_enb together 4 cycles -> fill_level stays 16, outputs the 4 oldest bytes, no overflow.
REQ-037 Write 5 bytes, pulse soft_reset concurrently with write_enb -> fill_level 0, empty=1, overflow/underflow 0, next read sets underflow=1.
REQ-038 Write 20 bytes with reads interleaved to cross pointer wrap -> data order preserved across wrap at entry 15->0.
REQ-039 Drop resetn mid-packet (after byte 6 of 14) -> all outputs at reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router FIFO: default byte width and the
// header field layout (length in DATA_W-1:2, destination address in 1:0).
package router_pkg;

   localparam int unsigned DATA_W_DEF   = 8;
   localparam int unsigned HDR_LEN_LSB  = 2;
   localparam int unsigned HDR_ADDR_MSB = 1;
   localparam int unsigned HDR_ADDR_LSB = 0;

   // Header byte layout at the default width.
   typedef struct packed {
      logic [DATA_W_DEF-1:HDR_LEN_LSB]   len;
      logic [HDR_ADDR_MSB:HDR_ADDR_LSB]  addr;
   } hdr_t;

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array for the router FIFO: one write port, one synchronous
// read port, no reset.
// Ports:
//   clk_i      - clock
//   wr_en_i    - write strobe
//   wr_addr_i  - write address
//   wr_data_i  - write data
//   rd_addr_i  - read address, sampled every clock
//   rd_data_o  - registered read data (write-first on address collision)
module router_fifo_mem #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     wr_en_i,
   input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
   output logic [WIDTH-1:0]         rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Write port plus synchronous read; a same-cycle write to the read
   // address is forwarded so the new head entry is visible immediately.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
         rd_data_q <= wr_data_i;
      end else begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/router_fifo_pkt.sv
// Packet-aware router FIFO: stores data bytes tagged with a header flag,
// tracks packet length on the read side and flags header / final byte.
// Ports:
//   clk, resetn            - clock, async active-low reset
//   soft_reset             - synchronous flush (highest priority)
//   write_enb, read_enb    - write / read requests
//   lfd_state, data_in     - header marker and write byte
//   data_out, data_valid   - read byte and its valid strobe (1-cycle latency)
//   sop_out, eop_out       - read byte is header / final byte of packet
//   empty, full, almost_full, fill_level - occupancy
//   overflow, underflow    - sticky error flags
module router_fifo_pkt
   import router_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned AF_LEVEL = DEPTH - 2
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       soft_reset,
   input  logic                       write_enb,
   input  logic                       read_enb,
   input  logic                       lfd_state,
   input  logic [DATA_W-1:0]          data_in,
   output logic [DATA_W-1:0]          data_out,
   output logic                       data_valid,
   output logic                       sop_out,
   output logic                       eop_out,
   output logic                       empty,
   output logic                       full,
   output logic                       almost_full,
   output logic [$clog2(DEPTH):0]     fill_level,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned FILL_W = PTR_W + 1;
   localparam int unsigned LEN_W  = DATA_W - HDR_LEN_LSB;
   localparam int unsigned CNT_W  = LEN_W + 1;

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;
   logic              afull_q, afull_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              valid_q, valid_d;
   logic              sop_q, sop_d;
   logic              eop_q, eop_d;

   logic              wr_acc_c;
   logic              rd_acc_c;
   logic [DATA_W:0]   wr_word_c;
   logic [DATA_W:0]   head_word;
   logic [LEN_W-1:0]  hdr_len_c;

   // Accept logic; a flush cycle accepts nothing.
   assign rd_acc_c  = read_enb & ~empty_q & ~soft_reset;
   assign wr_acc_c  = write_enb & (~full_q | rd_acc_c) & ~soft_reset;
   assign wr_word_c = {lfd_state, data_in};
   assign hdr_len_c = head_word[DATA_W-1:HDR_LEN_LSB];

   // Storage always prefetches the entry at the next read pointer, so the
   // head entry is ready in a register on the edge that accepts a read.
   router_fifo_mem #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk_i     (clk),
      .wr_en_i   (wr_acc_c),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (wr_word_c),
      .rd_addr_i (rd_ptr_d),
      .rd_data_o (head_word)
   );

   // Pointers, occupancy and flags derived from the next fill level.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (soft_reset) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         fill_d   = '0;
      end else begin
         if (wr_acc_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (rd_acc_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({wr_acc_c, rd_acc_c})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
         endcase
      end
      empty_d = (fill_d == '0);
      full_d  = (fill_d == FILL_W'(DEPTH));
      afull_d = (fill_d >= FILL_W'(AF_LEVEL));
   end

   // Sticky error flags, cleared only by a flush or reset.
   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (soft_reset) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end else begin
         if (write_enb && full_q && !rd_acc_c) ovf_d = 1'b1;
         if (read_enb && empty_q)              unf_d = 1'b1;
      end
   end

   // Read output stage and packet tracker. A header loads len+1 so the
   // count covers payload plus parity; the byte taking it 1->0 is the last.
   always_comb begin
      dout_d  = dout_q;
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      cnt_d   = cnt_q;
      if (soft_reset) begin
         dout_d = '0;
         cnt_d  = '0;
      end else if (rd_acc_c) begin
         dout_d  = head_word[DATA_W-1:0];
         valid_d = 1'b1;
         sop_d   = head_word[DATA_W];
         if (head_word[DATA_W]) begin
            cnt_d = CNT_W'(hdr_len_c) + CNT_W'(1);
         end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            eop_d = (cnt_q == CNT_W'(1));
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         cnt_q    <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         sop_q    <= 1'b0;
         eop_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         afull_q  <= afull_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         sop_q    <= sop_d;
         eop_q    <= eop_d;
      end
   end

   assign data_out    = dout_q;
   assign data_valid  = valid_q;
   assign sop_out     = sop_q;
   assign eop_out     = eop_q;
   assign empty       = empty_q;
   assign full        = full_q;
   assign almost_full = afull_q;
   assign fill_level  = fill_q;
   assign overflow    = ovf_q;
   assign underflow   = unf_q;

endmodule

// File: tb/tb_router_fifo_pkt.sv
// Directed self-checking bench for router_fifo_pkt (default parameters).
module tb_router_fifo_pkt;

   logic       clk;
   logic       resetn;
   logic       soft_reset;
   logic       write_enb;
   logic       read_enb;
   logic       lfd_state;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       data_valid;
   logic       sop_out;
   logic       eop_out;
   logic       empty;
   logic       full;
   logic       almost_full;
   logic [4:0] fill_level;
   logic       overflow;
   logic       underflow;

   int errors;
   int checks;

   logic [7:0] pkt [14];

   router_fifo_pkt dut (
      .clk         (clk),
      .resetn      (resetn),
      .soft_reset  (soft_reset),
      .write_enb   (write_enb),
      .read_enb    (read_enb),
      .lfd_state   (lfd_state),
      .data_in     (data_in),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .sop_out     (sop_out),
      .eop_out     (eop_out),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .fill_level  (fill_level),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock of stimulus; outputs are sampled 1ns after the edge.
   task automatic cyc(input logic we, input logic re, input logic lf, input logic [7:0] d);
      write_enb = we;
      read_enb  = re;
      lfd_state = lf;
      data_in   = d;
      @(posedge clk);
      #1;
      write_enb = 1'b0;
      read_enb  = 1'b0;
      lfd_state = 1'b0;
   endtask

   task automatic flush();
      soft_reset = 1'b1;
      @(posedge clk);
      #1;
      soft_reset = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_fill"},  32'(fill_level),  32'd0);
      check({tag, "_empty"}, 32'(empty),       32'd1);
      check({tag, "_full"},  32'(full),        32'd0);
      check({tag, "_afull"}, 32'(almost_full), 32'd0);
      check({tag, "_dout"},  32'(data_out),    32'd0);
      check({tag, "_valid"}, 32'(data_valid),  32'd0);
      check({tag, "_sop"},   32'(sop_out),     32'd0);
      check({tag, "_eop"},   32'(eop_out),     32'd0);
      check({tag, "_ovf"},   32'(overflow),    32'd0);
      check({tag, "_unf"},   32'(underflow),   32'd0);
   endtask

   initial begin
      errors     = 0;
      checks     = 0;
      resetn     = 1'b0;
      soft_reset = 1'b0;
      write_enb  = 1'b0;
      read_enb   = 1'b0;
      lfd_state  = 1'b0;
      data_in    = 8'h00;

      // Reset state
      #22;
      check_idle("rst");
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Packet: header 0x31 (len 12, addr 1), payload 0x40..0x4B, parity
      pkt[0]  = 8'h31;
      pkt[13] = 8'h31;
      for (int i = 1; i <= 12; i++) begin
         pkt[i]  = 8'(8'h3F + i);
         pkt[13] = pkt[13] ^ pkt[i];
      end
      for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, (i == 0), pkt[i]);
      check("pkt_fill_full", 32'(fill_level), 32'd14);
      check("pkt_afull", 32'(almost_full), 32'd1);
      for (int i = 0; i < 14; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 8'h00);
         check($sformatf("pkt_data%0d", i), 32'(data_out), 32'(pkt[i]));
         check($sformatf("pkt_valid%0d", i), 32'(data_valid), 32'd1);
         check($sformatf("pkt_sop%0d", i), 32'(sop_out), 32'(i == 0));
         check($sformatf("pkt_eop%0d", i), 32'(eop_out), 32'(i == 13));
         check($sformatf("pkt_fill%0d", i), 32'(fill_level), 32'(13 - i));
      end
      check("pkt_empty", 32'(empty), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      check("pkt_idle_valid", 32'(data_valid), 32'd0);
      check("pkt_idle_hold", 32'(data_out), 32'(pkt[13]));

      // Fill to full, pointers starting mid-array
      for (int i = 1; i <= 16; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 8'(8'h9F + i));
         check($sformatf("fill_lvl%0d", i), 32'(fill_level), 32'(i));
         check($sformatf("fill_af%0d", i), 32'(almost_full), 32'(i >= 14));
         check($sformatf("fill_full%0d", i), 32'(full), 32'(i == 16));
      end

      // Simultaneous read+write at full
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 8'(8'hC0 + k));
         check($sformatf("rw_data%0d", k), 32'(data_out), 32'(8'hA0 + k));
         check($sformatf("rw_fill%0d", k), 32'(fill_level), 32'd16);
         check($sformatf("rw_ovf%0d", k), 32'(overflow), 32'd0);
      end

      // Write while full is rejected
      cyc(1'b1, 1'b0, 1'b0, 8'hEE);
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_fill", 32'(fill_level), 32'd16);

      // Drain; rejected write did not land
      for (int k = 0; k < 16; k++) begin
         cyc(1'b0, 1'b1, 1'b0, 8'h00);
         if (k < 12) check($sformatf("drain%0d", k), 32'(data_out), 32'(8'hA4 + k));
         else        check($sformatf("drain%0d", k), 32'(data_out), 32'(8'hC0 + k - 12));
      end
      check("drain_empty", 32'(empty), 32'd1);

      // Soft reset concurrent with a write
      for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h50 + k));
      check("sr_pre_fill", 32'(fill_level), 32'd5);
      check("sr_pre_ovf", 32'(overflow), 32'd1);
      soft_reset = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 8'h99);
      soft_reset = 1'b0;
      check_idle("sr");
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      check("sr_unf", 32'(underflow), 32'd1);
      check("sr_unf_valid", 32'(data_valid), 32'd0);

      // Pointer wrap with interleaved reads
      flush();
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 8'(8'h64 + i));
         check($sformatf("wrap_data%0d", i), 32'(data_out), 32'(8'h60 + i));
         check($sformatf("wrap_fill%0d", i), 32'(fill_level), 32'd4);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 8'h00);
         check($sformatf("wrap_tail%0d", i), 32'(data_out), 32'(8'h70 + i));
      end
      check("wrap_empty", 32'(empty), 32'd1);
      check("wrap_unf", 32'(underflow), 32'd0);

      // Async reset mid-packet
      for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, (i == 0), pkt[i]);
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
      check("mid_data5", 32'(data_out), 32'(pkt[5]));
      check("mid_fill", 32'(fill_level), 32'd8);
      #2;
      resetn = 1'b0;
      #1;
      check_idle("arst");
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      check_idle("post");
      cyc(1'b1, 1'b0, 1'b0, 8'h07);
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      check("post_data", 32'(data_out), 32'h07);
      check("post_sop", 32'(sop_out), 32'd0);
      check("post_eop", 32'(eop_out), 32'd0);
      check("post_empty", 32'(empty), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
